inst_mem: RTL and testbench
===========================

INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in 32-bit words; power of two; ADDR_W = log2(DEPTH).
REQ-002 Parameter NOP_WORD, default 32'h00000013: word returned for every non-serviced fetch (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 im_addr  input  32  CPU fetch byte address.
REQ-006 op_code  output  32  instruction word for im_addr, to the CPU.
REQ-007 ld_start  input  1  single-cycle pulse that begins a program load at word 0.
REQ-008 ld_valid  input  1  loader byte valid.
REQ-009 ld_data  input  8  loader byte; little-endian byte order within each word.
REQ-010 ld_last  input  1  qualifies the final byte of the image; sampled only on a handshake.
REQ-011 ld_ready  output  1  memory can accept a loader byte.
REQ-012 cpu_reset  output  1  registered reset for the CPU, high while no valid image is running.
REQ-013 ld_done  output  1  sticky; a load completed since the last reset.
REQ-014 ld_err  output  1  sticky; bytes were dropped because the image exceeded DEPTH words.
REQ-015 ld_count  output  ADDR_W+1  number of words written by the current or most recent load.

Function
REQ-016 The FSM SHALL have exactly three states: HALT, LOAD and RUN.
REQ-017 HALT SHALL move to LOAD on ld_start. RUN SHALL move to LOAD on ld_start. LOAD SHALL move to RUN on the cycle after the ld_last handshake.
REQ-018 ld_start in LOAD SHALL restart the load: byte lane 0, word pointer 0, ld_count 0, ld_err cleared, memory contents kept.
REQ-019 ld_ready SHALL be 1 only in LOAD; a byte SHALL be accepted only on a cycle where ld_valid and ld_ready are both 1.
REQ-020 Accepted bytes SHALL fill lanes 0..3 of a word buffer; on the lane-3 byte the full word SHALL be written to mem[wr_ptr], and wr_ptr and ld_count SHALL each increment.
REQ-021 On an ld_last byte in lane k<3, the higher lanes SHALL be written as zero and the word committed in that same cycle.
REQ-022 When wr_ptr == DEPTH, further bytes SHALL still be accepted, no memory write SHALL occur, and ld_err SHALL be set; ld_count SHALL saturate at DEPTH.
REQ-023 cpu_reset SHALL be registered: 1 in every cycle where the state is not RUN, and 0 from the first RUN cycle onward.
REQ-024 ld_done SHALL be set on entry to RUN and cleared only by reset.
REQ-025 op_code SHALL be combinational from im_addr, with zero cycles of latency, because the CPU decodes op_code in the same cycle.
REQ-026 op_code SHALL equal mem[im_addr[ADDR_W+1:2]]; im_addr[1:0] SHALL be ignored.
REQ-027 op_code SHALL equal NOP_WORD when im_addr >= 4*DEPTH or when the state is not RUN.
REQ-028 Memory SHALL initialise to NOP_WORD at time zero and SHALL NOT be cleared by reset.
REQ-029 If ld_start coincides with a byte handshake, the ld_start SHALL win and the byte SHALL be discarded.

Reset
REQ-030 reset SHALL take priority over every other input.
REQ-031 On reset: state = HALT, cpu_reset = 1, ld_ready = 0, ld_done = 0, ld_err = 0, ld_count = 0, lane = 0, wr_ptr = 0, op_code = NOP_WORD.
REQ-032 Reset during LOAD SHALL abandon the partial word; words already committed SHALL remain in memory.

Structure
REQ-033 NOP_WORD and the state encoding (HALT, LOAD, RUN) SHALL live in a shared package, rv32i_pkg.
REQ-034 The byte-lane assembly and zero-padding logic SHALL be one sub-module, ld_packer, with outputs word and commit; the FSM, memory array and read mux SHALL stay in inst_mem.

Verification
REQ-035 Reset, then a fetch with im_addr = 0 -> op_code = 32'h00000013, cpu_reset = 1, ld_ready = 0.
REQ-036 ld_start, then bytes 13 05 A0 00 / 93 05 10 00 with ld_last on the last byte, then a fetch of 0x0 and 0x4 -> op_code = 0x00A00513, then 0x00100593; ld_count = 2; cpu_reset falls one cycle after the last byte; ld_done = 1.
REQ-037 5-byte image 13 05 A0 00 37 with ld_last on the 5th byte, then a fetch of 0x4 -> op_code = 0x00000037, ld_count = 2.
REQ-038 DEPTH = 4 with a 20-byte image -> ld_err = 1, ld_count = 4, word 3 intact, a fetch of 0x10 returns NOP_WORD.
REQ-039 ld_start in RUN -> cpu_reset = 1 on the next cycle, op_code = NOP_WORD; after re-loading word 0 = 0xDEADBEEF, a fetch of 0x0 returns 0xDEADBEEF.
REQ-040 reset asserted after 2 bytes of a word -> memory word unchanged, state = HALT, ld_count = 0; ld_valid held high with random stalls across the load -> no bytes lost or duplicated.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the instruction-memory slice: the canonical NOP
// and the loader/sequencer state encoding.
package rv32i_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    HALT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } im_state_t;

endpackage

// File: rtl/ld_packer.sv
// Assembles loader bytes little-endian into 32-bit words; a last byte in a
// low lane commits immediately with the upper lanes zero-filled.
module ld_packer
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic [31:0] word,
  output logic        commit
);

  logic [1:0]  lane;
  logic [23:0] held;

  assign commit = byte_en && ((lane == 2'd3) || byte_last);

  // The incoming byte is placed directly into the output word so a commit
  // never costs an extra cycle.
  always_comb begin
    word = '0;
    case (lane)
      2'd0:    word = {24'h0, byte_data};
      2'd1:    word = {16'h0, byte_data, held[7:0]};
      2'd2:    word = {8'h0, byte_data, held[15:0]};
      default: word = {byte_data, held};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= 2'd0;
      held <= '0;
    end else if (byte_en) begin
      if (commit) begin
        lane <= 2'd0;
      end else begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    held[7:0]   <= byte_data;
          2'd1:    held[15:8]  <= byte_data;
          default: held[23:16] <= byte_data;
        endcase
      end
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a byte-stream program loader; sequences the CPU
// reset around loads and serves fetches combinationally while running.
module inst_mem
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = rv32i_pkg::NOP_WORD,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       im_addr,
  output logic [31:0]       op_code,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  im_state_t       state;
  logic [ADDR_W:0] wr_ptr;
  logic            hs;
  logic            full;
  logic            commit;
  logic [31:0]     pk_word;

  // Contents survive reset; only power-up sets them to NOP.
  logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

  // ld_start wins over a coincident byte, which is then dropped.
  assign hs       = ld_ready && ld_valid && !ld_start;
  assign full     = (wr_ptr == FULL_CNT);
  assign ld_count = wr_ptr;

  ld_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (ld_start),
    .byte_en   (hs),
    .byte_data (ld_data),
    .byte_last (ld_last),
    .word      (pk_word),
    .commit    (commit)
  );

  always_ff @(posedge clk) begin
    if (!reset && commit && !full) begin
      mem[wr_ptr[ADDR_W-1:0]] <= pk_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HALT;
      ld_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      wr_ptr    <= '0;
    end else if (ld_start) begin
      state     <= LOAD;
      ld_ready  <= 1'b1;
      cpu_reset <= 1'b1;
      ld_err    <= 1'b0;
      wr_ptr    <= '0;
    end else if (hs) begin
      if (full) begin
        ld_err <= 1'b1;
      end else if (commit) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ld_last) begin
        state     <= RUN;
        ld_ready  <= 1'b0;
        cpu_reset <= 1'b0;
        ld_done   <= 1'b1;
      end
    end
  end

  always_comb begin
    op_code = NOP_WORD;
    if (state == RUN && im_addr[31:ADDR_W+2] == '0) begin
      op_code = mem[im_addr[ADDR_W+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: two depths driven in parallel, checked every cycle
// against a byte-queue model, plus literal fetches for the key scenarios.
module tb_inst_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] im_addr = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;

  logic [31:0] op_code_a, op_code_b;
  logic        ld_ready_a, ld_ready_b, cpu_reset_a, cpu_reset_b;
  logic        ld_done_a, ld_done_b, ld_err_a, ld_err_b;
  logic [8:0]  ld_count_a;
  logic [2:0]  ld_count_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .im_addr(im_addr), .op_code(op_code_a),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_a), .cpu_reset(cpu_reset_a), .ld_done(ld_done_a),
    .ld_err(ld_err_a), .ld_count(ld_count_a)
  );

  inst_mem #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .im_addr(im_addr), .op_code(op_code_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready_b), .cpu_reset(cpu_reset_b), .ld_done(ld_done_b),
    .ld_err(ld_err_b), .ld_count(ld_count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted bytes of the current load, the words they imply,
  // and a shared run/load/halt notion (0 halt, 1 load, 2 run).
  int          dep [2] = '{256, 4};
  logic [31:0] mm [2][256];
  logic [7:0]  acc [$];
  int          m_st = 0;
  bit          m_done = 1'b0;
  bit          m_last = 1'b0;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mm[d][i] = NOP;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_done = 1'b0; m_last = 1'b0; acc.delete();
    end else if (ld_start) begin
      m_st = 1; m_last = 1'b0; acc.delete();
    end else if (m_st == 1 && ld_valid) begin
      int k, w;
      logic [31:0] word;
      acc.push_back(ld_data);
      k = acc.size();
      if (k % 4 == 0 || ld_last) begin
        w = (k - 1) / 4;
        word = '0;
        for (int b = 4 * w; b < k; b++) word |= 32'(acc[b]) << (8 * (b - 4 * w));
        for (int d = 0; d < 2; d++) if (w < dep[d]) mm[d][w] = word;
      end
      if (ld_last) begin
        m_st = 2; m_done = 1'b1; m_last = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int k, words, ecnt;
        logic [31:0] eop;
        k = acc.size();
        words = m_last ? (k + 3) / 4 : k / 4;
        ecnt = (words < dep[d]) ? words : dep[d];
        eop = (m_st == 2 && longint'(im_addr) < 4 * dep[d]) ? mm[d][im_addr[31:2]] : NOP;
        chk($sformatf("op_code[%0d]", d), d == 0 ? op_code_a : op_code_b, eop);
        chk($sformatf("cpu_reset[%0d]", d), 32'(d == 0 ? cpu_reset_a : cpu_reset_b), 32'(m_st != 2));
        chk($sformatf("ld_ready[%0d]", d), 32'(d == 0 ? ld_ready_a : ld_ready_b), 32'(m_st == 1));
        chk($sformatf("ld_done[%0d]", d), 32'(d == 0 ? ld_done_a : ld_done_b), 32'(m_done));
        chk($sformatf("ld_err[%0d]", d), 32'(d == 0 ? ld_err_a : ld_err_b), 32'(k > 4 * dep[d]));
        chk($sformatf("ld_count[%0d]", d), d == 0 ? 32'(ld_count_a) : 32'(ld_count_b), 32'(ecnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; ld_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start();
    ld_start = 1'b1; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    if ($urandom_range(0, 3) == 0) tick();
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp_a,
                       input logic [31:0] exp_b);
    im_addr = addr;
    #1;
    chk({name, "_a"}, op_code_a, exp_a);
    chk({name, "_b"}, op_code_b, exp_b);
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    do_reset();
    chk_en = 1'b1;
    fetch("reset_fetch0", 32'h0, NOP, NOP);
    chk("reset_cpu_reset", 32'(cpu_reset_a), 32'd1);
    chk("reset_ld_ready", 32'(ld_ready_a), 32'd0);

    // Two-word image
    start();
    for (int i = 0; i < 7; i++) send(img[i], 1'b0);
    chk("cpu_reset_before_last", 32'(cpu_reset_a), 32'd1);
    send(img[7], 1'b1);
    chk("cpu_reset_after_last", 32'(cpu_reset_a), 32'd0);
    chk("two_word_done", 32'(ld_done_a), 32'd1);
    chk("two_word_count", 32'(ld_count_a), 32'd2);
    fetch("two_word_w0", 32'h0, 32'h00A0_0513, 32'h00A0_0513);
    fetch("two_word_w1", 32'h4, 32'h0010_0593, 32'h0010_0593);
    fetch("two_word_lowbits", 32'h7, 32'h0010_0593, 32'h0010_0593);

    // Five-byte image: last word zero-padded
    start();
    for (int i = 0; i < 4; i++) send(img[i], 1'b0);
    send(8'h37, 1'b1);
    chk("five_byte_count", 32'(ld_count_a), 32'd2);
    fetch("five_byte_w1", 32'h4, 32'h0000_0037, 32'h0000_0037);

    // Restart from RUN
    start();
    chk("restart_cpu_reset", 32'(cpu_reset_a), 32'd1);
    fetch("restart_fetch", 32'h0, NOP, NOP);
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'hDE, 1'b1);
    fetch("deadbeef_w0", 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    fetch("deadbeef_w1", 32'h4, 32'h0000_0037, 32'h0000_0037);

    // Reset in the middle of a word
    start();
    send(8'h44, 1'b0); send(8'h33, 1'b0); send(8'h22, 1'b0); send(8'h11, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    do_reset();
    chk("midreset_count", 32'(ld_count_a), 32'd0);
    chk("midreset_cpu_reset", 32'(cpu_reset_a), 32'd1);
    chk("midreset_ready", 32'(ld_ready_a), 32'd0);
    start();
    send(8'hAA, 1'b1);
    fetch("midreset_w0", 32'h0, 32'h0000_00AA, 32'h0000_00AA);
    fetch("midreset_w1_kept", 32'h4, 32'h0000_0037, 32'h0000_0037);

    // ld_start colliding with a byte: the byte is discarded
    start();
    ld_valid = 1'b1; ld_data = 8'h77; ld_start = 1'b1;
    tick();
    ld_valid = 1'b0; ld_start = 1'b0;
    send(8'h01, 1'b1);
    fetch("collide_w0", 32'h0, 32'h0000_0001, 32'h0000_0001);
    chk("collide_count", 32'(ld_count_a), 32'd1);

    // 20-byte image: overflows the DEPTH=4 instance
    start();
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), i == 19);
    chk("ovf_err_b", 32'(ld_err_b), 32'd1);
    chk("ovf_count_b", 32'(ld_count_b), 32'd4);
    chk("ovf_err_a", 32'(ld_err_a), 32'd0);
    chk("ovf_count_a", 32'(ld_count_a), 32'd5);
    fetch("ovf_w3", 32'hC, 32'h1F1E_1D1C, 32'h1F1E_1D1C);
    fetch("ovf_w4", 32'h10, 32'h2322_2120, NOP);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      ld_start = ($urandom_range(0, 59) == 0);
      ld_valid = ($urandom_range(0, 9) < 7);
      ld_data  = 8'($urandom);
      ld_last  = ($urandom_range(0, 24) == 0);
      im_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 191));
      tick();
    end
    reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
